// File: rtl/mcdf_ctrl_regs.sv
// MCDF control/status register block: per-channel enable/priority/length
// registers written over the cmd bus, plus read-only FIFO margin status.
module mcdf_ctrl_regs #(
    parameter int CHNL_NUM = 3,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MARGIN_W = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   cmd,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_data_w,
    output logic [DATA_W-1:0]            cmd_data_r,
    output logic                         cmd_err,
    input  logic [CHNL_NUM*MARGIN_W-1:0] slv_margin,
    output logic [CHNL_NUM-1:0]          chnl_en,
    output logic [2*CHNL_NUM-1:0]        prio,
    output logic [3*CHNL_NUM-1:0]        pkt_len
);

    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;
    localparam logic [1:0] CMD_RSV = 2'b11;
    localparam logic [5:0] CTRL_RST = 6'h07;

    logic [5:0]          ctrl [CHNL_NUM];
    logic [CHNL_NUM-1:0] ctrl_hit;
    logic [CHNL_NUM-1:0] stat_hit;
    logic [DATA_W-1:0]   rd_data;
    logic                err_nxt;

    // Exact-match decode; misaligned or out-of-range addresses hit nothing.
    always_comb begin
        ctrl_hit = '0;
        stat_hit = '0;
        rd_data  = '0;
        for (int i = 0; i < CHNL_NUM; i++) begin
            ctrl_hit[i] = (cmd_addr == ADDR_W'(4 * i));
            stat_hit[i] = (cmd_addr == ADDR_W'(16 + 4 * i));
            if (ctrl_hit[i])
                rd_data = rd_data | {{(DATA_W-6){1'b0}}, ctrl[i]};
            if (stat_hit[i])
                rd_data = rd_data | {{(DATA_W-MARGIN_W){1'b0}}, slv_margin[i*MARGIN_W +: MARGIN_W]};
        end
    end

    always_comb begin
        err_nxt = 1'b0;
        case (cmd)
            CMD_WR:  err_nxt = (ctrl_hit == '0);
            CMD_RD:  err_nxt = (ctrl_hit == '0) && (stat_hit == '0);
            CMD_RSV: err_nxt = 1'b1;
            default: err_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHNL_NUM; i++)
                ctrl[i] <= CTRL_RST;
        end else if (cmd == CMD_WR) begin
            for (int i = 0; i < CHNL_NUM; i++)
                if (ctrl_hit[i])
                    ctrl[i] <= cmd_data_w[5:0];
        end
    end

    // Read data holds between reads; an unmapped read decodes to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_data_r <= '0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= err_nxt;
            if (cmd == CMD_RD)
                cmd_data_r <= rd_data;
        end
    end

    for (genvar g = 0; g < CHNL_NUM; g++) begin : g_out
        assign chnl_en[g]        = ctrl[g][0];
        assign prio[2*g +: 2]    = ctrl[g][2:1];
        assign pkt_len[3*g +: 3] = ctrl[g][5:3];
    end

endmodule
